// File: rtl/uart_rx_fifo_if.sv
// Bus-side bundle for the UART receive FIFO.
// master drives pushes/pops/control, slave is the FIFO itself.
interface uart_rx_fifo_if #(
   parameter int PTR_W = 4
);
   logic [7:0]     wr_data;
   logic           wr_valid;
   logic           rd_en;
   logic [7:0]     rd_data;
   logic           empty;
   logic           full;
   logic [PTR_W:0] count;
   logic           flush;
   logic [PTR_W:0] threshold;
   logic           irq;
   logic           overrun;
   logic           overrun_clr;

   modport master (
      output wr_data, wr_valid, rd_en, flush,
      output threshold, overrun_clr,
      input  rd_data, empty, full, count,
      input  irq, overrun
   );

   modport slave (
      input  wr_data, wr_valid, rd_en, flush,
      input  threshold, overrun_clr,
      output rd_data, empty, full, count,
      output irq, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between UART receiver and register file:
// FWFT read, threshold irq, sticky overrun on dropped bytes.
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input logic           clk,
   input logic           reset,
   uart_rx_fifo_if.slave bus
);
   localparam int CW = PTR_W + 1;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_n;
   logic             irq_q;
   logic             ovr_q;
   logic             is_empty;
   logic             is_full;
   logic             pop;
   logic             push;
   logic             drop;

   assign is_empty = (cnt == '0);
   assign is_full  = (cnt == CW'(DEPTH));

   // A full FIFO still takes a byte if a pop frees a slot this cycle.
   always_comb begin
      pop   = 1'b0;
      push  = 1'b0;
      drop  = 1'b0;
      cnt_n = cnt;
      if (bus.flush) begin
         cnt_n = '0;
      end else begin
         pop   = bus.rd_en && !is_empty;
         push  = bus.wr_valid && (!is_full || pop);
         drop  = bus.wr_valid && is_full && !pop;
         cnt_n = cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         irq_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
         cnt   <= cnt_n;
         irq_q <= (bus.threshold != '0) &&
                  (cnt_n >= bus.threshold);
         if (drop)                 ovr_q <= 1'b1;
         else if (bus.overrun_clr) ovr_q <= 1'b0;
      end
   end

   assign bus.rd_data = is_empty ? 8'h00 : mem[rd_ptr];
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.count   = cnt;
   assign bus.irq     = irq_q;
   assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random
// traffic, all scored against a queue-based reference model.
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int PTR_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.PTR_W(PTR_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   byte unsigned q[$];
   bit m_ovr;
   bit m_irq;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h @%0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("rd_data", 32'(bus.rd_data),
          (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("irq", 32'(bus.irq), 32'(m_irq));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
   endtask

   task automatic cyc(input bit wv, input byte unsigned wd,
                      input bit re, input bit fl, input bit oc);
      int  thr;
      bit  pop;
      bit  drop;
      bus.wr_valid    = wv;
      bus.wr_data     = wd;
      bus.rd_en       = re;
      bus.flush       = fl;
      bus.overrun_clr = oc;
      thr = int'(bus.threshold);
      @(posedge clk);
      drop = 1'b0;
      if (fl) begin
         q.delete();
      end else begin
         pop  = re && (q.size() > 0);
         drop = wv && (q.size() == DEPTH) && !pop;
         if (pop) void'(q.pop_front());
         if (wv && !drop) q.push_back(wd);
      end
      if (drop)    m_ovr = 1'b1;
      else if (oc) m_ovr = 1'b0;
      m_irq = (thr != 0) && (q.size() >= thr);
      #1;
      check_all();
      bus.wr_valid    = 1'b0;
      bus.rd_en       = 1'b0;
      bus.flush       = 1'b0;
      bus.overrun_clr = 1'b0;
   endtask

   task automatic push(input byte unsigned d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop1();
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      reset           = 1'b1;
      bus.wr_valid    = 1'b0;
      bus.wr_data     = 8'h00;
      bus.rd_en       = 1'b0;
      bus.flush       = 1'b0;
      bus.overrun_clr = 1'b0;
      bus.threshold   = '0;
      m_ovr = 1'b0;
      m_irq = 1'b0;
      #12;
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // single byte
      push(8'hA5);
      chk("a5_data", 32'(bus.rd_data), 32'h0000_00A5);
      chk("a5_cnt", 32'(bus.count), 32'd1);
      pop1();
      chk("a5_empty", 32'(bus.empty), 32'd1);

      // fill, overrun, drain in order
      for (int i = 0; i < DEPTH; i++) push(byte'(i));
      chk("fill_full", 32'(bus.full), 32'd1);
      push(8'h55);
      chk("ovr_set", 32'(bus.overrun), 32'd1);
      chk("ovr_cnt", 32'(bus.count), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         chk("order", 32'(bus.rd_data), 32'(i));
         pop1();
      end
      chk("ovr_hold", 32'(bus.overrun), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("ovr_clr", 32'(bus.overrun), 32'd0);

      // wrap-around
      for (int i = 0; i < 10; i++) push(byte'($urandom));
      for (int i = 0; i < 10; i++) pop1();
      for (int i = 0; i < 12; i++) push(byte'($urandom));
      for (int i = 0; i < 12; i++) pop1();
      chk("wrap_cnt", 32'(bus.count), 32'd0);

      // push+pop while full
      for (int i = 0; i < DEPTH; i++) push(byte'(8'h10 + i));
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      chk("pp_cnt", 32'(bus.count), 32'd16);
      chk("pp_ovr", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) pop1();
      chk("pp_last", 32'(bus.rd_data), 32'h77);
      pop1();

      // empty push+pop: pop ignored
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      chk("ep_cnt", 32'(bus.count), 32'd1);
      pop1();

      // threshold irq
      bus.threshold = 5'd4;
      for (int i = 0; i < 3; i++) push(byte'(i));
      chk("irq_3", 32'(bus.irq), 32'd0);
      push(8'h03);
      chk("irq_4", 32'(bus.irq), 32'd1);
      pop1();
      chk("irq_pop", 32'(bus.irq), 32'd0);
      bus.threshold = 5'd0;
      for (int i = 0; i < 13; i++) push(byte'(i));
      chk("irq_dis", 32'(bus.irq), 32'd0);

      // flush with concurrent push, overrun preserved
      push(8'hEE);
      chk("fl_ovr_pre", 32'(bus.overrun), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      bus.threshold = 5'd2;
      for (int i = 0; i < 5; i++) push(byte'(i));
      cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      chk("fl_cnt", 32'(bus.count), 32'd0);
      chk("fl_irq", 32'(bus.irq), 32'd0);
      chk("fl_ovr", 32'(bus.overrun), 32'd1);

      // async reset mid-stream
      for (int i = 0; i < 6; i++) push(byte'(i + 8'h40));
      #2;
      reset = 1'b1;
      #1;
      q.delete();
      m_ovr = 1'b0;
      m_irq = 1'b0;
      check_all();
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0)
            bus.threshold = 5'($urandom_range(0, 31));
         cyc($urandom_range(0, 99) < 55,
             byte'($urandom),
             $urandom_range(0, 99) < 45,
             $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer. Sits directly downstream of the UART receiver FSM, between it and the bus-facing register file.
- Captures every byte strobed by the receiver's single-cycle data-valid pulse and holds it until software pops it.
- Raises a level interrupt when the fill count reaches a programmable threshold.
- Tracks overruns with a sticky flag.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- PTR_W, 4, log2(DEPTH); width of the read and write pointers.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_data  in  8  received byte from the receiver.
- wr_valid  in  1  single-cycle strobe; push wr_data.
- rd_en  in  1  pop the head entry (bus read of RX data register).
- rd_data  out  8  head entry, first-word-fall-through.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  current number of stored entries.
- flush  in  1  synchronous clear of contents.
- threshold  in  PTR_W+1  irq level; 0 disables irq.
- irq  out  1  registered level interrupt.
- overrun  out  1  sticky; a byte was dropped.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, irq=0, overrun=0, rd_data=0. Memory contents are don't-care.
- Storage: DEPTH x 8 array. Pointers are PTR_W bits wide and wrap naturally from DEPTH-1 to 0. Count is tracked separately, with PTR_W+1 bits.
- Push (wr_valid=1): mem[wr_ptr] <= wr_data and wr_ptr++. Accepted when !full, or when full and a pop occurs in the same cycle.
- Pop (rd_en=1, !empty): rd_ptr++. rd_en while empty is ignored; no pointer or count change.
- rd_data:
  - Combinational from mem[rd_ptr]; valid whenever empty=0.
  - A byte pushed in cycle N appears on rd_data with empty=0 in cycle N+1. Latency is 1 clock.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - both or neither: unchanged.
- Push while full with no pop: byte discarded; pointers and count unchanged; overrun <= 1 on the next edge.
- Simultaneous push and pop:
  - When full: both occur; count stays DEPTH; no overrun.
  - When empty: the pop is ignored; the push is accepted; count becomes 1.
- flush=1 (priority over push and pop in the same cycle):
  - wr_ptr, rd_ptr and count cleared; a concurrent wr_valid byte is discarded.
  - Does not clear overrun.
- Overrun flag:
  - Set by a dropped push; held until overrun_clr=1.
  - If overrun_clr and a new drop occur in the same cycle, set wins; overrun stays 1.
- empty and full are decoded from the registered count; they are glitch-free and update on the same edge as count.
- irq:
  - Registered: irq <= (threshold != 0) && (next_count >= threshold).
  - Asserts on the same edge where count reaches threshold.
  - Deasserts on the edge where count drops below threshold, or on flush.
  - threshold values greater than DEPTH mean irq never asserts.
- Receiver contract: wr_valid is never asserted on consecutive cycles at legal baud settings, but the FIFO accepts back-to-back pushes regardless.
- Reset mid-operation: immediate return to reset state; stored data is lost; no spurious irq on reset release.

Test Plan:
- Reset, then push 0xA5 (one wr_valid pulse) -> next cycle empty=0, count=1, rd_data=0xA5; pulse rd_en -> empty=1, count=0.
- Push 0x00..0x0F (16 bytes) -> full=1, count=16; push 0x55 -> overrun=1, count=16; pop 16 times -> rd_data sequence 0x00..0x0F in order (0x55 absent); overrun still 1 until overrun_clr pulse, then 0.
- Wrap-around: push 10, pop 10, push 12, pop 12 -> data matches pushes in order; pointers wrapped; count returns to 0.
- full=1, same-cycle wr_valid=1 (0x77) and rd_en=1 -> count stays 16, overrun=0, 0x77 read last after 15 pops.
- threshold=4: push 3 bytes -> irq=0; 4th push -> irq=1 on the same edge count=4; one pop -> irq=0; threshold=0 with 16 bytes -> irq=0.
- count=5, flush=1 together with wr_valid=1 -> count=0, empty=1, irq=0, overrun unchanged; assert reset mid-stream -> all outputs at reset values asynchronously.
